// File: rtl/output_port_scheduler.sv
// ==========================================================================
// output_port_scheduler: 5-way round-robin output port arbiter with credit
// flow control and flush; OUTPUT_PORT_SCHED_CACHE_PRIO_EN gives CACHE strict priority.  Rev 1.0
// ==========================================================================
`default_nettype none

`ifndef NETWORK_ADDRESS_WIDTH
`define NETWORK_ADDRESS_WIDTH 4
`endif
`ifndef CACHE_BANK_ADDRESS_WIDTH
`define CACHE_BANK_ADDRESS_WIDTH 2
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 16
`endif

module output_port_scheduler #(
   parameter int DEST_W  = `NETWORK_ADDRESS_WIDTH + `CACHE_BANK_ADDRESS_WIDTH,
   parameter int REQ_W   = `NETWORK_ADDRESS_WIDTH,
   parameter int DATA_W  = `DATA_WIDTH,
   parameter int CREDITS = 4,
   parameter int FLIT_W  = DEST_W + REQ_W + 2 + DATA_W
) (
   input  logic                clk_i,
   input  logic                reset_i,
   input  logic [4:0]          req_valid_i,
   input  logic [5*FLIT_W-1:0] req_flit_i,
   output logic [4:0]          req_ready_o,
   output logic                out_valid_o,
   output logic [FLIT_W-1:0]   out_flit_o,
   input  logic                credit_return_i,
   input  logic                flush_i,
   output logic                flush_done_o,
   output logic [3:0]          credit_cnt_o,
   output logic                credit_err_o
);

   localparam logic [3:0] c_credits_max = 4'(CREDITS);

   typedef enum logic [1:0] {
      ST_ACTIVE  = 2'd0,
      ST_FLUSH   = 2'd1,
      ST_FLUSHED = 2'd2
   } state_t;

`ifdef OUTPUT_PORT_SCHED_CACHE_PRIO_EN
   localparam int PTR_W = 2;
`else
   localparam int PTR_W = 3;
`endif

   state_t              state_q;
   logic [PTR_W-1:0]    ptr_q;
   logic [PTR_W-1:0]    ptr_d;
   logic                out_valid_q;
   logic [FLIT_W-1:0]   out_flit_q;
   logic [3:0]          credit_cnt_q;
   logic [3:0]          credit_cnt_d;
   logic                credit_err_q;
   logic                flush_done_q;

   logic                w_found;
   logic [2:0]          w_sel;
   logic [4:0]          w_grant;
   logic                w_err_set;
   logic [FLIT_W-1:0]   w_flit;
`ifdef OUTPUT_PORT_SCHED_CACHE_PRIO_EN
   logic [1:0]          w_ring;
`else
   logic [3:0]          w_ring;
`endif

   // First valid requester at or after ptr; grants only while ACTIVE with a credit.
   always_comb begin
      w_found = 1'b0;
      w_sel   = 3'd0;
      w_ring  = '0;
      w_grant = 5'd0;
      if (state_q == ST_ACTIVE && credit_cnt_q != 4'd0) begin
`ifdef OUTPUT_PORT_SCHED_CACHE_PRIO_EN
         if (req_valid_i[4]) begin
            w_found = 1'b1;
            w_sel   = 3'd4;
         end else begin
            for (int k = 0; k < 4; k++) begin
               w_ring = ptr_q + 2'(k);
               if (!w_found && req_valid_i[w_ring]) begin
                  w_found = 1'b1;
                  w_sel   = {1'b0, w_ring};
               end
            end
         end
`else
         for (int k = 0; k < 5; k++) begin
            w_ring = {1'b0, ptr_q} + 4'(k);
            if (w_ring >= 4'd5) begin
               w_ring = w_ring - 4'd5;
            end
            if (!w_found && req_valid_i[w_ring[2:0]]) begin
               w_found = 1'b1;
               w_sel   = w_ring[2:0];
            end
         end
`endif
         if (w_found) begin
            w_grant = 5'd1 << w_sel;
         end
      end
   end

   // CACHE grants leave the N/S/E/W ring pointer untouched in priority mode.
   always_comb begin
      ptr_d = ptr_q;
      if (w_found) begin
`ifdef OUTPUT_PORT_SCHED_CACHE_PRIO_EN
         if (w_sel != 3'd4) begin
            ptr_d = w_sel[1:0] + 2'd1;
         end
`else
         ptr_d = (w_sel == 3'd4) ? 3'd0 : w_sel + 3'd1;
`endif
      end
   end

   assign w_flit = req_flit_i[int'(w_sel)*FLIT_W +: FLIT_W];

   always_comb begin
      credit_cnt_d = credit_cnt_q;
      w_err_set    = 1'b0;
      if (w_found && !credit_return_i) begin
         credit_cnt_d = credit_cnt_q - 4'd1;
      end else if (!w_found && credit_return_i) begin
         if (credit_cnt_q == c_credits_max) begin
            w_err_set = 1'b1;
         end else begin
            credit_cnt_d = credit_cnt_q + 4'd1;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q      <= ST_ACTIVE;
         ptr_q        <= '0;
         out_valid_q  <= 1'b0;
         out_flit_q   <= '0;
         credit_cnt_q <= c_credits_max;
         credit_err_q <= 1'b0;
         flush_done_q <= 1'b0;
      end else begin
         out_valid_q  <= w_found;
         if (w_found) begin
            out_flit_q <= w_flit;
         end
         ptr_q        <= ptr_d;
         credit_cnt_q <= credit_cnt_d;
         if (w_err_set) begin
            credit_err_q <= 1'b1;
         end
         case (state_q)
            ST_ACTIVE: begin
               if (flush_i) begin
                  state_q <= ST_FLUSH;
               end
            end
            ST_FLUSH: begin
               // Drained: park if flush is still requested, otherwise resume directly.
               if (credit_cnt_d == c_credits_max) begin
                  if (flush_i) begin
                     state_q      <= ST_FLUSHED;
                     flush_done_q <= 1'b1;
                  end else begin
                     state_q <= ST_ACTIVE;
                  end
               end
            end
            ST_FLUSHED: begin
               if (!flush_i) begin
                  state_q      <= ST_ACTIVE;
                  flush_done_q <= 1'b0;
               end
            end
            default: begin
               state_q      <= ST_ACTIVE;
               flush_done_q <= 1'b0;
            end
         endcase
      end
   end

   assign req_ready_o  = w_grant;
   assign out_valid_o  = out_valid_q;
   assign out_flit_o   = out_flit_q;
   assign credit_cnt_o = credit_cnt_q;
   assign credit_err_o = credit_err_q;
   assign flush_done_o = flush_done_q;

endmodule

`default_nettype wire

// File: tb/tb_output_port_scheduler.sv
// ==========================================================================
// tb_output_port_scheduler: table-driven directed bench for the output port scheduler.  Rev 1.0
// ==========================================================================
`default_nettype none

module tb_output_port_scheduler;

   localparam int FW = 28;

   logic            clk;
   logic            reset;
   logic [4:0]      req_valid;
   logic [5*FW-1:0] req_flit;
   logic [4:0]      req_ready;
   logic            out_valid;
   logic [FW-1:0]   out_flit;
   logic            credit_return;
   logic            flush;
   logic            flush_done;
   logic [3:0]      credit_cnt;
   logic            credit_err;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [4:0] v;
      logic       ret;
      logic       fl;
      logic [4:0] rdy;
      logic       ov;
      int         idx;
      logic [3:0] cnt;
      logic       done;
      logic       err;
   } vec_t;

   vec_t tbl[$];

   output_port_scheduler #(
      .DEST_W(6), .REQ_W(4), .DATA_W(16), .CREDITS(4)
   ) dut (
      .clk_i          (clk),
      .reset_i        (reset),
      .req_valid_i    (req_valid),
      .req_flit_i     (req_flit),
      .req_ready_o    (req_ready),
      .out_valid_o    (out_valid),
      .out_flit_o     (out_flit),
      .credit_return_i(credit_return),
      .flush_i        (flush),
      .flush_done_o   (flush_done),
      .credit_cnt_o   (credit_cnt),
      .credit_err_o   (credit_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [FW-1:0] flit_of(input int i);
      return FW'((i + 1) * 28'h0123457) ^ 28'h8000000;
   endfunction

   function automatic vec_t mk(input logic [4:0] v, input logic ret, input logic fl,
                               input logic [4:0] rdy, input logic ov, input int idx,
                               input logic [3:0] cnt, input logic done, input logic err);
      vec_t r;
      r.v = v; r.ret = ret; r.fl = fl; r.rdy = rdy; r.ov = ov;
      r.idx = idx; r.cnt = cnt; r.done = done; r.err = err;
      return r;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic run_row(input vec_t r, input int n);
      req_valid     = r.v;
      credit_return = r.ret;
      flush         = r.fl;
      #1;
      chk($sformatf("req_ready[%0d]", n), 32'(req_ready), 32'(r.rdy));
      @(posedge clk);
      #1;
      chk($sformatf("out_valid[%0d]", n), 32'(out_valid), 32'(r.ov));
      chk($sformatf("out_flit[%0d]", n), 32'(out_flit), 32'(flit_of(r.idx)));
      chk($sformatf("credit_cnt[%0d]", n), 32'(credit_cnt), 32'(r.cnt));
      chk($sformatf("flush_done[%0d]", n), 32'(flush_done), 32'(r.done));
      chk($sformatf("credit_err[%0d]", n), 32'(credit_err), 32'(r.err));
   endtask

   task automatic do_reset(input int cycles);
      reset         = 1'b1;
      req_valid     = 5'd0;
      credit_return = 1'b0;
      flush         = 1'b0;
      repeat (cycles) @(posedge clk);
      #1;
      chk("rst out_valid", 32'(out_valid), 32'd0);
      chk("rst out_flit", 32'(out_flit), 32'd0);
      chk("rst req_ready", 32'(req_ready), 32'd0);
      chk("rst credit_cnt", 32'(credit_cnt), 32'd4);
      chk("rst flush_done", 32'(flush_done), 32'd0);
      chk("rst credit_err", 32'(credit_err), 32'd0);
      reset = 1'b0;
   endtask

   initial begin
      int last;
      vec_t seq6[3];
      for (int i = 0; i < 5; i++) req_flit[i*FW +: FW] = flit_of(i);

      // Rotation with all requesters valid, returning a credit after the first send.
      for (int k = 0; k < 6; k++) begin
`ifdef OUTPUT_PORT_SCHED_CACHE_PRIO_EN
         tbl.push_back(mk(5'h1F, k != 0, 1'b0, 5'b10000, 1'b1, 4, 4'd3, 1'b0, 1'b0));
         last = 4;
`else
         tbl.push_back(mk(5'h1F, k != 0, 1'b0, 5'(1 << (k % 5)), 1'b1, k % 5, 4'd3, 1'b0, 1'b0));
         last = k % 5;
`endif
      end
      tbl.push_back(mk(5'h00, 1'b1, 1'b0, 5'h00, 1'b0, last, 4'd4, 1'b0, 1'b0));
      // Credit exhaustion with only N valid.
      for (int k = 0; k < 4; k++)
         tbl.push_back(mk(5'h01, 1'b0, 1'b0, 5'h01, 1'b1, 0, 4'(3 - k), 1'b0, 1'b0));
      tbl.push_back(mk(5'h01, 1'b0, 1'b0, 5'h00, 1'b0, 0, 4'd0, 1'b0, 1'b0));
      tbl.push_back(mk(5'h01, 1'b1, 1'b0, 5'h00, 1'b0, 0, 4'd1, 1'b0, 1'b0));
      tbl.push_back(mk(5'h01, 1'b0, 1'b0, 5'h01, 1'b1, 0, 4'd0, 1'b0, 1'b0));
      tbl.push_back(mk(5'h00, 1'b0, 1'b0, 5'h00, 1'b0, 0, 4'd0, 1'b0, 1'b0));
      // Refill, send+return at full, stray return sets sticky error.
      for (int k = 0; k < 4; k++)
         tbl.push_back(mk(5'h00, 1'b1, 1'b0, 5'h00, 1'b0, 0, 4'(k + 1), 1'b0, 1'b0));
      tbl.push_back(mk(5'h01, 1'b1, 1'b0, 5'h01, 1'b1, 0, 4'd4, 1'b0, 1'b0));
      tbl.push_back(mk(5'h00, 1'b1, 1'b0, 5'h00, 1'b0, 0, 4'd4, 1'b0, 1'b1));
      tbl.push_back(mk(5'h01, 1'b0, 1'b0, 5'h01, 1'b1, 0, 4'd3, 1'b0, 1'b1));
      tbl.push_back(mk(5'h01, 1'b0, 1'b0, 5'h01, 1'b1, 0, 4'd2, 1'b0, 1'b1));
      tbl.push_back(mk(5'h01, 1'b1, 1'b0, 5'h01, 1'b1, 0, 4'd2, 1'b0, 1'b1));
      // Held flush: same-cycle grant completes, drain, park, release.
      tbl.push_back(mk(5'h01, 1'b0, 1'b1, 5'h01, 1'b1, 0, 4'd1, 1'b0, 1'b1));
      tbl.push_back(mk(5'h01, 1'b1, 1'b1, 5'h00, 1'b0, 0, 4'd2, 1'b0, 1'b1));
      tbl.push_back(mk(5'h01, 1'b1, 1'b1, 5'h00, 1'b0, 0, 4'd3, 1'b0, 1'b1));
      tbl.push_back(mk(5'h01, 1'b1, 1'b1, 5'h00, 1'b0, 0, 4'd4, 1'b1, 1'b1));
      tbl.push_back(mk(5'h01, 1'b0, 1'b1, 5'h00, 1'b0, 0, 4'd4, 1'b1, 1'b1));
      tbl.push_back(mk(5'h01, 1'b0, 1'b0, 5'h00, 1'b0, 0, 4'd4, 1'b0, 1'b1));
      tbl.push_back(mk(5'h01, 1'b0, 1'b0, 5'h01, 1'b1, 0, 4'd3, 1'b0, 1'b1));
      // Pulsed flush: drain then straight back to ACTIVE.
      tbl.push_back(mk(5'h00, 1'b0, 1'b1, 5'h00, 1'b0, 0, 4'd3, 1'b0, 1'b1));
      tbl.push_back(mk(5'h01, 1'b0, 1'b0, 5'h00, 1'b0, 0, 4'd3, 1'b0, 1'b1));
      tbl.push_back(mk(5'h01, 1'b1, 1'b0, 5'h00, 1'b0, 0, 4'd4, 1'b0, 1'b1));
      tbl.push_back(mk(5'h01, 1'b0, 1'b0, 5'h01, 1'b1, 0, 4'd3, 1'b0, 1'b1));

`ifdef OUTPUT_PORT_SCHED_CACHE_PRIO_EN
      seq6[0] = mk(5'h11, 1'b0, 1'b0, 5'h10, 1'b1, 4, 4'd3, 1'b0, 1'b0);
      seq6[1] = mk(5'h03, 1'b0, 1'b0, 5'h01, 1'b1, 0, 4'd2, 1'b0, 1'b0);
      seq6[2] = mk(5'h11, 1'b0, 1'b0, 5'h10, 1'b1, 4, 4'd1, 1'b0, 1'b0);
`else
      seq6[0] = mk(5'h11, 1'b0, 1'b0, 5'h01, 1'b1, 0, 4'd3, 1'b0, 1'b0);
      seq6[1] = mk(5'h03, 1'b0, 1'b0, 5'h02, 1'b1, 1, 4'd2, 1'b0, 1'b0);
      seq6[2] = mk(5'h11, 1'b0, 1'b0, 5'h10, 1'b1, 4, 4'd1, 1'b0, 1'b0);
`endif

      do_reset(2);
      @(posedge clk);
      #1;
      foreach (tbl[n]) run_row(tbl[n], n);

      // Mid-operation reset clears the sticky error and pointer, then CACHE vs ring priority.
      do_reset(1);
      for (int n = 0; n < 3; n++) run_row(seq6[n], 100 + n);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
